mm2_load_unit: RTL and testbench
================================

# mm2_load_unit

- Memory-stage-2 load return unit.
- Consumes the load descriptor held in the mm1→mm2 pipeline register and waits for the data-memory read response issued from mm1.
- Aligns and sign/zero-extends the returned word and presents the result to writeback.
- Drives the pipeline stall that holds the mm1/mm2 registers while a response is outstanding, and drains responses belonging to flushed loads.

## Interface

Parameters:
- TIMEOUT, default 64: max stall cycles before forced completion (used only with the timeout feature).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; the load currently in mm2 is killed.
- mm2_mm_re  in  1  instruction in mm2 is a load with a request outstanding.
- mm2_mm_access_sz  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- mm2_mm_addr_l  in  2  address bits [1:0].
- mm2_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- data_rvalid  in  1  read response valid, one-cycle pulse per request.
- data_rdata  in  32  read response word.
- stall  out  1  hold mm1/mm2 pipeline registers (drives their wen low); combinational.
- ld_valid  out  1  ld_data valid this cycle; registered.
- ld_data  out  32  aligned, extended load result; registered.
- ld_err  out  1  forced completion by timeout; registered, pulses with ld_valid.

## Operation

- FSM states: IDLE, WAIT, DONE, DRAIN. Reset → IDLE; ld_valid=0, ld_data=0, ld_err=0, counter=0.

IDLE
- mm2_mm_re=0: stall=0.
  - A data_rvalid arriving here is ignored.
- mm2_mm_re=1, flush=0: stall=1.
  - If data_rvalid: capture and go to DONE.
  - Otherwise go to WAIT.
- mm2_mm_re=1, flush=1: stall=0.
  - If data_rvalid: discard and stay in IDLE.
  - Otherwise go to DRAIN.

WAIT
- stall=1.
- If data_rvalid: capture and go to DONE. This takes priority over flush; the flush applies to the completed load, so ld_valid is suppressed.
- Else if flush: go to DRAIN.

DONE
- stall=0, ld_valid=1. The load is still in mm2 with mm2_mm_re=1 but must not be restarted.
- Always go to IDLE.

DRAIN
- stall = mm2_mm_re, so a new load cannot enter service until the stale response returns.
- On data_rvalid: discard and go to IDLE.

Capture:
- ld_data is loaded only on capture.
- ld_valid=1 only in DONE, and only when the captured load was not flushed on its capture cycle.

Alignment:
- Byte: rdata[8*addr_l +: 8].
- Half: addr_l[1] ? rdata[31:16] : rdata[15:0]; addr_l[0] is ignored.
- Word: rdata unmodified.
- Byte/half: bit 7/15 replicated when mm2_ld_unsigned=0, else zero-filled.

Protocol guarantees:
- At most one request is outstanding; stall holds mm1, so no new request issues until capture or drain completes.

## Timing

- Load in mm2 at cycle N, data_rvalid at cycle M≥N:
  - stall is high in cycles N..M.
  - ld_valid and ld_data are valid in cycle M+1, with stall=0.
  - The pipeline advances at the end of M+1.
- Minimum occupancy of mm2 is 2 cycles (M=N).
- Flush at cycle F while waiting: stall=0 in F.
  - Following loads stall in DRAIN until the stale rvalid arrives.
  - The first cycle a new load can be serviced is the cycle after that rvalid.
- Reset mid-operation: next cycle state=IDLE and all outputs are zero. The memory side shares rst_n, so no stale response follows.

## Configuration

- Macro: LD_TIMEOUT_EN.
- Defined:
  - A counter increments on each stall cycle of a live load (IDLE with a request, and WAIT). It clears on leaving WAIT and on flush.
  - When the counter reaches TIMEOUT with no rvalid: go to DONE with ld_data=0 and ld_err=1 for that one cycle.
  - The late response is ignored, because it arrives in IDLE with mm2_mm_re=0 or is absorbed as in DRAIN.
  - Counter width: $clog2(TIMEOUT+1).
- Undefined: no counter; WAIT never times out; ld_err is tied to 0.

## Test plan

- Word load, addr_l=0, rvalid same cycle, rdata=0x89ABCDEF → stall=1 for 1 cycle; next cycle ld_valid=1, ld_data=0x89ABCDEF.
- Byte load, addr_l=2, rdata=0x12F45678, signed → ld_data=0xFFFFFFF4; repeat unsigned → 0x000000F4. Half load, addr_l=2, signed → 0x000012F4.
- Half load, rvalid 5 cycles after entry, rdata=0x0000807F, signed → stall high 6 cycles, then ld_data=0xFFFF807F with ld_valid for exactly 1 cycle.
- Flush 2 cycles into WAIT, next load arrives immediately, stale rvalid 3 cycles later → first load never produces ld_valid; second load stalls until after the stale rvalid, then completes normally with its own data.
- Reset asserted in WAIT → next cycle stall=0, ld_valid=0, ld_data=0, state IDLE.
- With LD_TIMEOUT_EN and TIMEOUT=4, no rvalid → after 4 stall cycles, ld_valid=1, ld_err=1, ld_data=0; a late rvalid is ignored. Without the macro, the same stimulus keeps stall=1 indefinitely.

Source files
------------

// File: rtl/mm2_load_unit.sv
// mm2_load_unit: memory-stage-2 load return unit.
//
// Takes the load descriptor in the mm1->mm2 pipeline register and waits for
// the data-memory read response. Aligns and sign/zero-extends the returned
// word for writeback. Stalls mm1/mm2 while a response is outstanding and
// drains responses that belong to flushed loads.
//
// Optional feature: define LD_TIMEOUT_EN to force completion (ld_err=1,
// ld_data=0) after TIMEOUT stall cycles without a response. Without it,
// ld_err is tied to 0.
//
// Ports:
//   clk               clock
//   rst_n             synchronous active-low reset
//   flush             pipeline flush; kills the load in mm2
//   mm2_mm_re         load in mm2 with a request outstanding
//   mm2_mm_access_sz  00 byte, 01 half, 10/11 word
//   mm2_mm_addr_l     address bits [1:0]
//   mm2_ld_unsigned   1 = zero-extend, 0 = sign-extend
//   data_rvalid       read response valid (one pulse per request)
//   data_rdata        read response word
//   stall             hold mm1/mm2 pipeline registers (combinational)
//   ld_valid          ld_data valid this cycle (registered)
//   ld_data           aligned, extended load result (registered)
//   ld_err            forced completion by timeout (registered)
module mm2_load_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mm2_mm_re,
  input  logic [1:0]  mm2_mm_access_sz,
  input  logic [1:0]  mm2_mm_addr_l,
  input  logic        mm2_ld_unsigned,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        ld_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        capture;     // response accepted for the load in mm2
  logic        capture_ok;  // ...and that load was not flushed
  logic        timeout_hit;
  logic [31:0] aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    capture_ok = 1'b0;
    unique case (state)
      IDLE: begin
        if (mm2_mm_re) begin
          if (!flush) begin
            if (data_rvalid) begin
              capture    = 1'b1;
              capture_ok = 1'b1;
              state_next = DONE;
            end else if (timeout_hit) begin
              state_next = DONE;
            end else begin
              state_next = WAIT;
            end
          end else if (!data_rvalid) begin
            state_next = DRAIN;
          end
        end
      end
      WAIT: begin
        // A response in the flush cycle still completes the load, but the
        // flush suppresses its ld_valid.
        if (data_rvalid) begin
          capture    = 1'b1;
          capture_ok = !flush;
          state_next = DONE;
        end else if (flush) begin
          state_next = DRAIN;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      DRAIN: begin
        if (data_rvalid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: stall
  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = mm2_mm_re && !flush;
      // A flush without a response releases the pipeline in that cycle.
      WAIT:    stall = data_rvalid || !flush;
      DONE:    stall = 1'b0;
      DRAIN:   stall = mm2_mm_re;
      default: stall = 1'b0;
    endcase
  end

  // Alignment and extension
  always_comb begin
    byte_sel = data_rdata[7:0];
    unique case (mm2_mm_addr_l)
      2'd0: byte_sel = data_rdata[7:0];
      2'd1: byte_sel = data_rdata[15:8];
      2'd2: byte_sel = data_rdata[23:16];
      2'd3: byte_sel = data_rdata[31:24];
      default: byte_sel = data_rdata[7:0];
    endcase
    half_sel = mm2_mm_addr_l[1] ? data_rdata[31:16] : data_rdata[15:0];
    unique case (mm2_mm_access_sz)
      2'b00:   aligned = {{24{!mm2_ld_unsigned && byte_sel[7]}}, byte_sel};
      2'b01:   aligned = {{16{!mm2_ld_unsigned && half_sel[15]}}, half_sel};
      default: aligned = data_rdata;
    endcase
  end

  // Result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_valid <= 1'b0;
      ld_data  <= '0;
    end else begin
      ld_valid <= capture_ok || timeout_hit;
      if (capture) begin
        ld_data <= aligned;
      end else if (timeout_hit) begin
        ld_data <= '0;
      end
    end
  end

`ifdef LD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          live_stall;

  // Stall cycles of a live (unflushed) load; a response overrides the count.
  assign live_stall  = ((state == IDLE) && mm2_mm_re && !flush) ||
                       ((state == WAIT) && !flush);
  assign timeout_hit = live_stall && !data_rvalid &&
                       ((32'(cnt) + 32'd1) == TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (live_stall && (state_next == WAIT)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= timeout_hit;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign ld_err         = 1'b0;
`endif

endmodule

// File: tb/tb_mm2_load_unit.sv
// Directed testbench for mm2_load_unit. Every cycle the driver states what
// stall/ld_valid/ld_err (and, where relevant, ld_data) must be, derived from
// the cycle-level timing rules; expected load results come from an
// arithmetic alignment model or from hand-computed literals.
module tb_mm2_load_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mm_re;
  logic [1:0]  access_sz;
  logic [1:0]  addr_l;
  logic        ld_unsigned;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_err;

  logic        chk_en;
  logic        exp_stall;
  logic        exp_valid;
  logic        exp_err;
  logic        chk_data;
  logic [31:0] exp_data;

  int unsigned n_checks;
  int unsigned n_pass;

  mm2_load_unit #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .mm2_mm_re        (mm_re),
    .mm2_mm_access_sz (access_sz),
    .mm2_mm_addr_l    (addr_l),
    .mm2_ld_unsigned  (ld_unsigned),
    .data_rvalid      (rvalid),
    .data_rdata       (rdata),
    .stall            (stall),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .ld_err           (ld_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference load result from plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] sz, input logic [1:0] a,
                                        input logic u, input logic [31:0] rd);
    int unsigned v;
    case (sz)
      2'b00: begin
        v = (rd >> (8 * int'(a))) & 32'd255;
        if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (a >= 2'd2) ? (rd >> 16) : (rd & 32'd65535);
        if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (stall === exp_stall) n_pass++;
      else $display("FAIL stall t=%0t got %b exp %b", $time, stall, exp_stall);
      n_checks++;
      if (ld_valid === exp_valid) n_pass++;
      else $display("FAIL ld_valid t=%0t got %b exp %b", $time, ld_valid, exp_valid);
      n_checks++;
      if (ld_err === exp_err) n_pass++;
      else $display("FAIL ld_err t=%0t got %b exp %b", $time, ld_err, exp_err);
      if (chk_data) begin
        n_checks++;
        if (ld_data === exp_data) n_pass++;
        else $display("FAIL ld_data t=%0t got %h exp %h", $time, ld_data, exp_data);
      end
    end
  end

  // One cycle: drive inputs and state this cycle's expected outputs.
  task automatic cyc(input logic r, input logic fl, input logic rv, input logic [31:0] rd,
                     input logic es, input logic ev, input logic ee,
                     input logic cd, input logic [31:0] ed);
    mm_re     = r;
    flush     = fl;
    rvalid    = rv;
    rdata     = rd;
    exp_stall = es;
    exp_valid = ev;
    exp_err   = ee;
    chk_data  = cd;
    exp_data  = ed;
    @(posedge clk);
    #1;
  endtask

  // Load entering mm2, response after dly cycles, result next cycle.
  task automatic load(input logic [1:0] sz, input logic [1:0] a, input logic u,
                      input logic [31:0] rd, input int unsigned dly,
                      input logic [31:0] expect_val);
    access_sz   = sz;
    addr_l      = a;
    ld_unsigned = u;
    for (int unsigned i = 0; i < dly; i++) cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    cyc(1, 0, 1, rd, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, '0, 0, 1, 0, 1, expect_val);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    chk_en      = 1'b0;
    rst_n       = 1'b0;
    mm_re       = 1'b0;
    flush       = 1'b0;
    rvalid      = 1'b0;
    rdata       = '0;
    access_sz   = 2'b10;
    addr_l      = 2'd0;
    ld_unsigned = 1'b0;
    exp_stall   = 1'b0;
    exp_valid   = 1'b0;
    exp_err     = 1'b0;
    chk_data    = 1'b0;
    exp_data    = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    // Reset state
    cyc(0, 0, 0, '0, 0, 0, 0, 1, 32'h0);
    rst_n = 1'b1;
    cyc(0, 0, 0, '0, 0, 0, 0, 1, 32'h0);

    // Hand-computed literals
    load(2'b10, 2'd0, 1'b0, 32'h89AB_CDEF, 0, 32'h89AB_CDEF);
    load(2'b00, 2'd2, 1'b0, 32'h12F4_5678, 0, 32'hFFFF_FFF4);
    load(2'b00, 2'd2, 1'b1, 32'h12F4_5678, 0, 32'h0000_00F4);
    load(2'b01, 2'd2, 1'b0, 32'h12F4_5678, 0, 32'h0000_12F4);
    load(2'b01, 2'd0, 1'b0, 32'h0000_807F, 5, 32'hFFFF_807F);

    // Model-based patterns
    load(2'b00, 2'd1, 1'b0, 32'hA5B6_C7D8, 1, model(2'b00, 2'd1, 1'b0, 32'hA5B6_C7D8));
    load(2'b00, 2'd3, 1'b1, 32'hA5B6_C7D8, 2, model(2'b00, 2'd3, 1'b1, 32'hA5B6_C7D8));
    load(2'b00, 2'd0, 1'b0, 32'h1234_5670, 0, model(2'b00, 2'd0, 1'b0, 32'h1234_5670));
    load(2'b01, 2'd3, 1'b0, 32'h9ABC_0001, 1, model(2'b01, 2'd3, 1'b0, 32'h9ABC_0001));
    load(2'b01, 2'd1, 1'b1, 32'h0000_F00D, 0, model(2'b01, 2'd1, 1'b1, 32'h0000_F00D));
    load(2'b11, 2'd2, 1'b0, 32'hDEAD_BEEF, 3, model(2'b11, 2'd2, 1'b0, 32'hDEAD_BEEF));

    // Response with no load in mm2 is ignored
    cyc(0, 0, 1, 32'h1111_1111, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, '0);

    // Flush in WAIT, next load waits behind the stale response
    access_sz = 2'b10;
    addr_l    = 2'd0;
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);           // IDLE -> WAIT
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);           // WAIT
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);           // WAIT
    cyc(1, 1, 0, '0, 0, 0, 0, 0, '0);           // flush -> DRAIN
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);           // next load held
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    cyc(1, 0, 1, 32'hBAD0_BAD0, 1, 0, 0, 0, '0); // stale response
    load(2'b10, 2'd0, 1'b0, 32'h600D_600D, 1, 32'h600D_600D);

    // Flush in IDLE with same-cycle response: discarded
    cyc(1, 1, 1, 32'hBAD1_BAD1, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, '0);

    // Flush in IDLE without response: drain
    cyc(1, 1, 0, '0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, '0);           // DRAIN, no load
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);           // DRAIN, load held
    cyc(1, 0, 1, 32'hBAD2_BAD2, 1, 0, 0, 0, '0);
    load(2'b00, 2'd1, 1'b1, 32'h0000_AB00, 0, 32'h0000_00AB);

    // Response and flush together in WAIT: completes without ld_valid
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    cyc(1, 1, 1, 32'hBAD3_BAD3, 1, 0, 0, 0, '0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, '0);
    load(2'b10, 2'd0, 1'b0, 32'h7777_0001, 0, 32'h7777_0001);

    // Reset while in WAIT
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    rst_n = 1'b0;
    cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    rst_n = 1'b1;
    cyc(0, 0, 0, '0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, '0, 0, 0, 0, 1, 32'h0);

    // No response: timeout or indefinite stall
    load(2'b10, 2'd0, 1'b0, 32'h5555_AAAA, 0, 32'h5555_AAAA);
`ifdef LD_TIMEOUT_EN
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, '0, 0, 1, 1, 1, 32'h0);
    cyc(0, 0, 1, 32'hCAFE_CAFE, 0, 0, 0, 0, '0); // late response ignored
    cyc(0, 0, 0, '0, 0, 0, 0, 1, 32'h0);
`else
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, '0, 1, 0, 0, 0, '0);
    cyc(1, 0, 1, 32'hCAFE_CAFE, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, '0, 0, 1, 0, 1, 32'hCAFE_CAFE);
    cyc(0, 0, 0, '0, 0, 0, 0, 0, '0);
`endif

    chk_en = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
